coherence_control: RTL and testbench
====================================

// Module: coherence_control
// PURPOSE
//  Memory/coherence controller: the responder on the cache_control_if bus for two cores.
//  Arbitrates icache fetches, dcache writebacks and coherent dcache transactions onto one RAM port.
//  Issues snoops to the non-requesting dcache and forwards dirty data cache-to-cache, writing it to RAM.
//  Sits between the per-core icache/dcache pairs and the RAM model.
// PARAMETERS
//  CPUS    2   number of cores; only 2 is supported (snooper = the other core)
//  WORD_W  32  data/address word width
// PORTS
//  CLK          in   1             clock, rising edge
//  nRST         in   1             reset, asynchronous, active-low
//  iREN         in   CPUS          icache read request per core
//  iaddr        in   CPUS x WORD_W icache word address
//  iwait        out  CPUS          0 = iload valid / request complete this cycle
//  iload        out  CPUS x WORD_W instruction word
//  dREN, dWEN   in   CPUS          dcache word read / write request
//  daddr        in   CPUS x WORD_W dcache word address
//  dstore       in   CPUS x WORD_W dcache write data
//  dwait        out  CPUS          0 = dcache word accepted/returned this cycle
//  dload        out  CPUS x WORD_W dcache read data
//  cctrans      in   CPUS          requester: coherent transaction active; snooper: responding
//  ccwrite      in   CPUS          requester: wants exclusive (invalidate others)
//  ccwait       out  CPUS          1 = core is being snooped; hold off its own requests
//  ccinv        out  CPUS          1 = snooped core must invalidate the line
//  ccsnoopaddr  out  CPUS x WORD_W snoop address (= daddr of requester)
//  ramREN/WEN   out  1             RAM read / write strobe
//  ramaddr      out  WORD_W        RAM address
//  ramstore     out  WORD_W        RAM write data
//  ramload      in   WORD_W        RAM read data
//  ramstate     in   2             0 FREE, 1 BUSY, 2 ACCESS (word done), 3 ERROR
// BEHAVIOUR
//  Defaults every cycle: iwait=dwait='1, ccwait=ccinv=0, ramREN=ramWEN=0, ramaddr/ramstore/loads=0.
//  Reset: state IDLE, grant g=0, rr pointers=0; all outputs at defaults. Reset mid-op aborts it.
//  FSM states: IDLE, IFETCH, DWB, SNOOP, C2C, MEMRD; g = latched granted core, s = ~g.
//  IDLE priority: any cctrans -> SNOOP; else any dWEN -> DWB; else any iREN -> IFETCH.
//   Ties between cores resolved round-robin: separate d/i pointers; the winner's pointer then
//   points at the other core. Grant is decided and latched on the IDLE->X edge; no output in IDLE.
//  IFETCH: ramREN=1, ramaddr=iaddr[g]; on ramstate==ACCESS: iwait[g]=0, iload[g]=ramload -> IDLE.
//  DWB (non-coherent writeback, one word): ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g];
//   on ACCESS: dwait[g]=0 -> IDLE. A second word is re-arbitrated from IDLE.
//  SNOOP (hub, min 1 cycle): ccwait[s]=1, ccsnoopaddr[s]=daddr[g], ccinv[s]=ccwrite[g].
//   Next: !cctrans[g] -> IDLE; elif dWEN[s] -> C2C; elif dREN[g] -> MEMRD; else stay.
//  C2C: ccwait[s] held; ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s], dload[g]=dstore[s];
//   on ACCESS: dwait[s]=0 and (if dREN[g]) dwait[g]=0 in the same cycle -> SNOOP.
//  MEMRD: ccwait[s] held; ramREN=1, ramaddr=daddr[g]; on ACCESS: dwait[g]=0,
//   dload[g]=ramload -> SNOOP.
//  Each handshake = exactly one cycle of wait low per word; loads valid only in that cycle.
//  ramstate BUSY/FREE/ERROR: hold state and strobes, waits stay 1 (no timeout).
//  Upgrade (cctrans+ccwrite, no dREN/dWEN): ccinv pulses in SNOOP until cctrans[g] drops; no RAM cycle.
//  cctrans of s while s is snooped = response only; never a new grant until return to IDLE.
// TESTING
//  1 Reset: nRST=0 -> iwait=dwait=2'b11, ccwait=0, ramREN=ramWEN=0; all hold 1 cycle after release.
//  2 iREN[0], iaddr 0x100; ACCESS after 2 BUSY, ramload 0xDEADBEEF -> iwait[0]=0 one cycle, iload[0]=0xDEADBEEF.
//  3 cctrans[0]+dREN[0] @0x200, core1 silent -> ccwait[1]=1, ccsnoopaddr[1]=0x200, ramREN@0x200, dload[0]=ramload.
//  4 As 3 but core1 dWEN, dstore 0x1234 -> ramWEN, ramstore 0x1234, dload[0]=0x1234, dwait both 0 same cycle.
//  5 cctrans on both cores same cycle after reset -> core0 served first, core1 next; next tie goes to core0.
//  6 cctrans[1]+ccwrite[1], no dREN -> ccinv[0]=1 until cctrans[1]=0, then IDLE; ramREN/WEN never set.

Source files
------------

// File: rtl/coherence_control_if.sv
// Bus between two cores' icache/dcache pairs, the coherence controller and the RAM model.
// Handshake: a requester holds REN/WEN (and address/data) steady until its wait line is
// low for exactly one cycle; that cycle completes one word and is the only cycle loads are valid.
interface coherence_control_if #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
);
  logic [CPUS-1:0]             iREN, iwait;
  logic [CPUS-1:0][WORD_W-1:0] iaddr, iload;
  logic [CPUS-1:0]             dREN, dWEN, dwait;
  logic [CPUS-1:0][WORD_W-1:0] daddr, dstore, dload;
  logic [CPUS-1:0]             cctrans, ccwrite, ccwait, ccinv;
  logic [CPUS-1:0][WORD_W-1:0] ccsnoopaddr;
  logic                        ramREN, ramWEN;
  logic [WORD_W-1:0]           ramaddr, ramstore, ramload;
  logic [1:0]                  ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_control.sv
// Two-core coherence controller: arbitrates icache fetches, dcache writebacks and snooped
// dcache transactions onto a single RAM port, with cache-to-cache forwarding of dirty data.
module coherence_control #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  coherence_control_if.slave ccif,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFETCH = 3'd1,
    DWB    = 3'd2,
    SNOOP  = 3'd3,
    C2C    = 3'd4,
    MEMRD  = 3'd5
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'b10;

  state_t state, next;
  logic   g, g_next;
  logic   d_rr, d_rr_next;
  logic   i_rr, i_rr_next;
  logic   s;
  logic   access;

  assign s         = ~g;
  assign access    = (ccif.ramstate == RAM_ACCESS);
  assign dbg_state = state;

  // Lone requester wins outright; on a tie the round-robin pointer decides.
  function automatic logic pick(input logic [CPUS-1:0] req, input logic ptr);
    if (&req) pick = ptr;
    else      pick = req[1];
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      g     <= 1'b0;
      d_rr  <= 1'b0;
      i_rr  <= 1'b0;
    end else begin
      state <= next;
      g     <= g_next;
      d_rr  <= d_rr_next;
      i_rr  <= i_rr_next;
    end
  end

  always_comb begin
    ccif.iwait       = '1;
    ccif.dwait       = '1;
    ccif.ccwait      = '0;
    ccif.ccinv       = '0;
    ccif.iload       = '0;
    ccif.dload       = '0;
    ccif.ccsnoopaddr = '0;
    ccif.ramREN      = 1'b0;
    ccif.ramWEN      = 1'b0;
    ccif.ramaddr     = '0;
    ccif.ramstore    = '0;
    next      = state;
    g_next    = g;
    d_rr_next = d_rr;
    i_rr_next = i_rr;

    case (state)
      IDLE: begin
        // Coherent traffic and writebacks share the d pointer; fetches use their own.
        if (|ccif.cctrans) begin
          g_next    = pick(ccif.cctrans, d_rr);
          d_rr_next = ~g_next;
          next      = SNOOP;
        end else if (|ccif.dWEN) begin
          g_next    = pick(ccif.dWEN, d_rr);
          d_rr_next = ~g_next;
          next      = DWB;
        end else if (|ccif.iREN) begin
          g_next    = pick(ccif.iREN, i_rr);
          i_rr_next = ~g_next;
          next      = IFETCH;
        end
      end

      IFETCH: begin
        ccif.ramREN  = 1'b1;
        ccif.ramaddr = ccif.iaddr[g];
        if (access) begin
          ccif.iwait[g] = 1'b0;
          ccif.iload[g] = ccif.ramload;
          next          = IDLE;
        end
      end

      DWB: begin
        ccif.ramWEN   = 1'b1;
        ccif.ramaddr  = ccif.daddr[g];
        ccif.ramstore = ccif.dstore[g];
        if (access) begin
          ccif.dwait[g] = 1'b0;
          next          = IDLE;
        end
      end

      SNOOP: begin
        ccif.ccwait[s]      = 1'b1;
        ccif.ccsnoopaddr[s] = ccif.daddr[g];
        ccif.ccinv[s]       = ccif.ccwrite[g];
        // The snooped core's cctrans here is only a response, never a new request.
        if (!ccif.cctrans[g])  next = IDLE;
        else if (ccif.dWEN[s]) next = C2C;
        else if (ccif.dREN[g]) next = MEMRD;
      end

      C2C: begin
        ccif.ccwait[s] = 1'b1;
        ccif.ramWEN    = 1'b1;
        ccif.ramaddr   = ccif.daddr[s];
        ccif.ramstore  = ccif.dstore[s];
        if (access) begin
          ccif.dwait[s] = 1'b0;
          ccif.dload[g] = ccif.dstore[s];
          if (ccif.dREN[g]) ccif.dwait[g] = 1'b0;
          next = SNOOP;
        end
      end

      MEMRD: begin
        ccif.ccwait[s] = 1'b1;
        ccif.ramREN    = 1'b1;
        ccif.ramaddr   = ccif.daddr[g];
        if (access) begin
          ccif.dwait[g] = 1'b0;
          ccif.dload[g] = ccif.ramload;
          next          = SNOOP;
        end
      end

      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coherence_control.sv
// Self-checking bench for coherence_control: a RAM model with programmable BUSY latency,
// per-scenario tasks, and expected-value queues for loads and RAM writes.
module tb_coherence_control;
  localparam int         W      = 32;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SNP  = 3'd3;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic [2:0]   dbg_state;
  logic [3:0]   busy_n = 4'd2;
  logic [3:0]   ram_cnt;
  logic [W-1:0] ram_data = '0;

  int checks = 0;
  int failures = 0;

  logic [W-1:0]   exp_q[$];
  logic [2*W-1:0] ram_q[$];

  always #5 CLK = ~CLK;

  coherence_control_if #(.CPUS(2), .WORD_W(W)) bus();

  coherence_control #(.CPUS(2), .WORD_W(W)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .ccif      (bus.slave),
    .dbg_state (dbg_state)
  );

  // RAM model: busy_n BUSY cycles, then one ACCESS cycle per strobed word.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) ram_cnt <= '0;
    else if (!(bus.ramREN | bus.ramWEN) || bus.ramstate == 2'b10) ram_cnt <= '0;
    else ram_cnt <= ram_cnt + 4'd1;
  end
  assign bus.ramstate = (bus.ramREN | bus.ramWEN) ? ((ram_cnt == busy_n) ? 2'b10 : 2'b01) : 2'b00;
  assign bus.ramload  = ram_data;

  task automatic clear_inputs();
    bus.iREN = '0; bus.iaddr = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.daddr = '0; bus.dstore = '0; bus.cctrans = '0; bus.ccwrite = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (bus.iwait !== 2'b11) begin failures++; $display("FAIL reset_iwait got=%b exp=11", bus.iwait); end
    checks++; if (bus.dwait !== 2'b11) begin failures++; $display("FAIL reset_dwait got=%b exp=11", bus.dwait); end
    checks++; if (bus.ccwait !== 2'b00 || bus.ccinv !== 2'b00) begin failures++; $display("FAIL reset_cc got=%b/%b exp=00/00", bus.ccwait, bus.ccinv); end
    checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b00) begin failures++; $display("FAIL reset_ram got=%b exp=00", {bus.ramREN, bus.ramWEN}); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    nRST = 1'b1;
    @(negedge CLK);
    checks++; if (bus.iwait !== 2'b11 || bus.dwait !== 2'b11) begin failures++; $display("FAIL post_reset_waits got=%b/%b exp=11/11", bus.iwait, bus.dwait); end
    checks++; if ({bus.ramREN, bus.ramWEN, bus.ccwait} !== 4'b0000) begin failures++; $display("FAIL post_reset_ctrl got=%b exp=0000", {bus.ramREN, bus.ramWEN, bus.ccwait}); end
  endtask

  task automatic test_ifetch();
    bit done;
    logic [W-1:0] e;
    busy_n = 4'd2; ram_data = 32'hDEADBEEF;
    @(negedge CLK);
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h100;
    exp_q.push_back(32'hDEADBEEF);
    done = 1'b0;
    for (int n = 1; n <= 20 && !done; n++) begin
      @(negedge CLK);
      if (bus.iwait[0] === 1'b0) begin
        done = 1'b1;
        e = exp_q.pop_front();
        checks++; if (bus.iload[0] !== e) begin failures++; $display("FAIL ifetch_iload got=%h exp=%h", bus.iload[0], e); end
        checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h100) begin failures++; $display("FAIL ifetch_ram got=%b/%h exp=1/00000100", bus.ramREN, bus.ramaddr); end
        checks++; if (n != 3) begin failures++; $display("FAIL ifetch_latency got=%0d exp=3", n); end
        checks++; if (bus.iwait[1] !== 1'b1) begin failures++; $display("FAIL ifetch_other_iwait got=%b exp=1", bus.iwait[1]); end
        bus.iREN[0] = 1'b0;
      end
    end
    if (!done) begin checks++; failures++; $display("FAIL ifetch_timeout got=none exp=handshake"); end
    @(negedge CLK);
    checks++; if (bus.iwait !== 2'b11 || dbg_state !== S_IDLE) begin failures++; $display("FAIL ifetch_one_cycle got=%b/%0d exp=11/0", bus.iwait, dbg_state); end
  endtask

  task automatic test_snoop_memrd();
    bit done;
    logic [W-1:0] e;
    busy_n = 4'd2; ram_data = 32'hCAFE0001;
    @(negedge CLK);
    bus.cctrans[0] = 1'b1; bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h200;
    exp_q.push_back(32'hCAFE0001);
    done = 1'b0;
    for (int n = 1; n <= 20 && !done; n++) begin
      @(negedge CLK);
      if (n == 1) begin
        checks++; if (dbg_state !== S_SNP || bus.ccwait !== 2'b10 || bus.ccsnoopaddr[1] !== 32'h200 || bus.ccinv !== 2'b00)
          begin failures++; $display("FAIL snoop_hub got=%0d/%b/%h/%b exp=3/10/00000200/00", dbg_state, bus.ccwait, bus.ccsnoopaddr[1], bus.ccinv); end
      end
      if (bus.dwait[0] === 1'b0) begin
        done = 1'b1;
        e = exp_q.pop_front();
        checks++; if (bus.dload[0] !== e) begin failures++; $display("FAIL memrd_dload got=%h exp=%h", bus.dload[0], e); end
        checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h200 || bus.ccwait !== 2'b10)
          begin failures++; $display("FAIL memrd_ram got=%b/%h/%b exp=1/00000200/10", bus.ramREN, bus.ramaddr, bus.ccwait); end
        checks++; if (n != 4) begin failures++; $display("FAIL memrd_latency got=%0d exp=4", n); end
        bus.dREN[0] = 1'b0; bus.cctrans[0] = 1'b0;
      end
    end
    if (!done) begin checks++; failures++; $display("FAIL memrd_timeout got=none exp=handshake"); end
    repeat (2) @(negedge CLK);
    checks++; if (dbg_state !== S_IDLE || bus.ccwait !== 2'b00) begin failures++; $display("FAIL memrd_release got=%0d/%b exp=0/00", dbg_state, bus.ccwait); end
  endtask

  task automatic test_c2c();
    bit done, saw_ren, responded;
    logic [W-1:0] e;
    logic [2*W-1:0] r;
    busy_n = 4'd1; ram_data = 32'h0BAD0BAD;
    @(negedge CLK);
    bus.cctrans[0] = 1'b1; bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h240;
    exp_q.push_back(32'h1234);
    ram_q.push_back({32'h240, 32'h1234});
    done = 1'b0; saw_ren = 1'b0; responded = 1'b0;
    for (int n = 1; n <= 20 && !done; n++) begin
      @(negedge CLK);
      if (bus.ramREN === 1'b1) saw_ren = 1'b1;
      if (bus.dwait[0] === 1'b0) begin
        done = 1'b1;
        e = exp_q.pop_front();
        r = ram_q.pop_front();
        checks++; if (bus.dload[0] !== e) begin failures++; $display("FAIL c2c_dload got=%h exp=%h", bus.dload[0], e); end
        checks++; if (bus.dwait[1] !== 1'b0) begin failures++; $display("FAIL c2c_dwait_both got=%b exp=0", bus.dwait[1]); end
        checks++; if (bus.ramWEN !== 1'b1 || {bus.ramaddr, bus.ramstore} !== r)
          begin failures++; $display("FAIL c2c_ramwrite got=%b/%h exp=1/%h", bus.ramWEN, {bus.ramaddr, bus.ramstore}, r); end
        clear_inputs();
      end else if (bus.ccwait[1] === 1'b1 && !responded) begin
        responded = 1'b1;
        bus.cctrans[1] = 1'b1; bus.dWEN[1] = 1'b1; bus.daddr[1] = 32'h240; bus.dstore[1] = 32'h1234;
      end
    end
    if (!done) begin checks++; failures++; $display("FAIL c2c_timeout got=none exp=handshake"); end
    repeat (2) @(negedge CLK);
    checks++; if (dbg_state !== S_IDLE || saw_ren) begin failures++; $display("FAIL c2c_release got=%0d/%b exp=0/0", dbg_state, saw_ren); end
  endtask

  task automatic test_round_robin();
    bit seen;
    logic [W-1:0] e, obs;
    clear_inputs();
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    bus.cctrans = 2'b11;
    for (int k = 0; k < 3; k++) begin
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
        @(negedge CLK);
        if (bus.ccwait !== 2'b00) seen = 1'b1;
      end
      if (!seen) begin checks++; failures++; $display("FAIL rr_timeout_%0d got=none exp=snoop", k); end
      else begin
        obs = bus.ccwait[1] ? 32'd0 : 32'd1;
        e = exp_q.pop_front();
        checks++; if (obs !== e) begin failures++; $display("FAIL rr_grant_%0d got=%0d exp=%0d", k, obs, e); end
        bus.cctrans[obs[0]] = 1'b0;
        @(negedge CLK);
        checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL rr_idle_%0d got=%0d exp=0", k, dbg_state); end
        if (bus.cctrans == 2'b00 && k < 2) bus.cctrans = 2'b11;
      end
    end
    clear_inputs();
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_upgrade();
    @(negedge CLK);
    bus.cctrans[1] = 1'b1; bus.ccwrite[1] = 1'b1; bus.daddr[1] = 32'h400;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++; if (bus.ccinv !== 2'b01 || bus.ccwait !== 2'b01 || bus.ccsnoopaddr[0] !== 32'h400 || {bus.ramREN, bus.ramWEN} !== 2'b00)
        begin failures++; $display("FAIL upgrade_%0d got=%b/%b/%h/%b exp=01/01/00000400/00", i, bus.ccinv, bus.ccwait, bus.ccsnoopaddr[0], {bus.ramREN, bus.ramWEN}); end
    end
    bus.cctrans[1] = 1'b0; bus.ccwrite[1] = 1'b0;
    @(negedge CLK);
    checks++; if (bus.ccinv !== 2'b00 || dbg_state !== S_IDLE) begin failures++; $display("FAIL upgrade_end got=%b/%0d exp=00/0", bus.ccinv, dbg_state); end
  endtask

  task automatic test_back_to_back();
    bit done;
    int words;
    logic [W-1:0] e;
    logic [2*W-1:0] r;
    busy_n = 4'd0; ram_data = 32'h55AA_1234;
    @(negedge CLK);
    bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h300; bus.dstore[0] = 32'hA0;
    bus.iREN[1] = 1'b1; bus.iaddr[1] = 32'h500;
    ram_q.push_back({32'h300, 32'hA0}); ram_q.push_back({32'h304, 32'hA1});
    exp_q.push_back(32'h55AA_1234);
    done = 1'b0; words = 0;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge CLK);
      if (bus.dwait[0] === 1'b0) begin
        r = ram_q.pop_front();
        checks++; if (bus.ramWEN !== 1'b1 || {bus.ramaddr, bus.ramstore} !== r)
          begin failures++; $display("FAIL dwb_word%0d got=%b/%h exp=1/%h", words, bus.ramWEN, {bus.ramaddr, bus.ramstore}, r); end
        words++;
        if (words == 1) begin bus.daddr[0] = 32'h304; bus.dstore[0] = 32'hA1; end
        else bus.dWEN[0] = 1'b0;
      end
      if (bus.iwait[1] === 1'b0) begin
        done = 1'b1;
        e = exp_q.pop_front();
        checks++; if (words != 2) begin failures++; $display("FAIL b2b_priority got=%0d exp=2", words); end
        checks++; if (bus.iload[1] !== e || bus.ramaddr !== 32'h500) begin failures++; $display("FAIL b2b_iload got=%h/%h exp=%h/00000500", bus.iload[1], bus.ramaddr, e); end
        bus.iREN[1] = 1'b0;
      end
    end
    if (!done) begin checks++; failures++; $display("FAIL b2b_timeout got=none exp=handshake"); end
    @(negedge CLK);
    checks++; if (ram_q.size() != 0 || exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", ram_q.size(), exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_snoop_memrd();
    test_c2c();
    test_round_robin();
    test_upgrade();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
